// File: rtl/fft_mem_sched_if.sv
// Scheduler-to-datapath bundle: start/busy/done handshake, bank read/write
// addresses, swap selects, twiddle address and PE bypass.
`timescale 1ns/1ps
interface fft_mem_sched_if #(
  parameter int AW = 6,
  parameter int SW = 4
);
  logic          start;
  logic          busy;
  logic          done;
  logic [SW-1:0] stage;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic          rd_swap;
  logic [AW-1:0] tf_addr;
  logic          bypass_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr_a;
  logic [AW-1:0] wr_addr_b;
  logic          wr_swap;

  modport master (
    input  start,
    output busy, done, stage,
    output rd_addr_a, rd_addr_b, rd_swap, tf_addr, bypass_n,
    output wr_en, wr_addr_a, wr_addr_b, wr_swap
  );

  modport slave (
    output start,
    input  busy, done, stage,
    input  rd_addr_a, rd_addr_b, rd_swap, tf_addr, bypass_n,
    input  wr_en, wr_addr_a, wr_addr_b, wr_swap
  );
endinterface

// File: rtl/fft_mem_sched.sv
// Stage/address scheduler for the in-place radix-2 FFT: one read per cycle per stage,
// writes follow reads by LAT cycles; stage period M+LAT, done pulses after the final write.
`timescale 1ns/1ps
module fft_mem_sched #(
  parameter int LOG2N = 8,
  parameter int LAT   = 2,
  parameter int SW    = 4
) (
  input  logic           Clk,
  input  logic           Reset_n,
  fft_mem_sched_if.master bus
);
  localparam int            AW         = LOG2N - 2;
  localparam int            DW         = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [SW-1:0] LAST_STG   = SW'(LOG2N - 2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          rd_cnt_q, rd_cnt_d;
  logic [DW-1:0]          drn_cnt_q, drn_cnt_d;
  logic [SW-1:0]          stage_q, stage_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [LAT-1:0]         pv_q, pv_d;
  logic [LAT-1:0][AW-1:0] pc_q, pc_d;

  logic                   rd_vld;
  logic                   wr_vld;
  logic [AW-1:0]          wr_cnt;
  logic [SW:0]            k_ext;
  logic [AW-1:0]          m_cur;
  logic [AW-1:0]          m_prev;
  logic [AW-1:0]          m_next;

  logic [AW-1:0]          rd_addr_a_c, rd_addr_b_c, tf_addr_c;
  logic [AW-1:0]          wr_addr_a_c, wr_addr_b_c;
  logic                   rd_swap_c, wr_swap_c, bypass_n_c;

  // mask(k): top k bits of an AW-bit word set; k >= AW gives all ones.
  function automatic logic [AW-1:0] mask_f(input logic [SW:0] k);
    return ~({AW{1'b1}} >> k);
  endfunction

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    drn_cnt_d = drn_cnt_q;
    stage_d   = stage_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = READ;
          rd_cnt_d = '0;
          stage_d  = '0;
          busy_d   = 1'b1;
        end
      end
      READ: begin
        rd_cnt_d = rd_cnt_q + AW'(1);
        if (&rd_cnt_q) begin
          state_d   = DRAIN;
          drn_cnt_d = '0;
        end
      end
      DRAIN: begin
        drn_cnt_d = drn_cnt_q + DW'(1);
        if (drn_cnt_q == DRAIN_LAST) begin
          if (stage_q == LAST_STG) begin
            state_d = IDLE;
            stage_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = READ;
            rd_cnt_d = '0;
            stage_d  = stage_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_vld = (state_q == READ);

  // Read-to-write delay line; stage is not carried because DRAIN flushes it first.
  always_comb begin
    pv_d    = '0;
    pc_d    = '0;
    pv_d[0] = rd_vld;
    pc_d[0] = rd_vld ? rd_cnt_q : '0;
    for (int i = 1; i < LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pc_d[i] = pc_q[i-1];
    end
  end

  assign wr_vld = pv_q[LAT-1];
  assign wr_cnt = pc_q[LAT-1];
  assign k_ext  = {1'b0, stage_q};
  assign m_cur  = mask_f(k_ext);
  assign m_prev = mask_f(k_ext - (SW+1)'(1));
  assign m_next = mask_f(k_ext + (SW+1)'(1));

  always_comb begin
    rd_addr_a_c = '0;
    rd_addr_b_c = '0;
    tf_addr_c   = '0;
    rd_swap_c   = 1'b0;
    if (rd_vld) begin
      rd_addr_a_c = rd_cnt_q;
      rd_addr_b_c = rd_cnt_q ^ m_cur;
      tf_addr_c   = rd_cnt_q << stage_q;
      // Lowest bit of mask(k) is bit AW-k.
      rd_swap_c   = (stage_q != '0) && (|(rd_cnt_q & m_cur & ~m_prev));
    end
  end

  always_comb begin
    wr_addr_a_c = '0;
    wr_addr_b_c = '0;
    wr_swap_c   = 1'b0;
    if (wr_vld) begin
      wr_addr_a_c = wr_cnt;
      wr_addr_b_c = wr_cnt ^ m_cur;
      // Bit just below mask(k), i.e. bit AW-1-k.
      wr_swap_c   = (stage_q != LAST_STG) && (|(wr_cnt & m_next & ~m_cur));
    end
  end

  // Bypass covers the whole last stage, including words still in the PE during DRAIN.
  assign bypass_n_c = ~(busy_q && (stage_q == LAST_STG));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
      drn_cnt_q <= '0;
      stage_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pv_q      <= '0;
      pc_q      <= '0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      drn_cnt_q <= drn_cnt_d;
      stage_q   <= stage_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pv_q      <= pv_d;
      pc_q      <= pc_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_q;
  assign bus.rd_addr_a = rd_addr_a_c;
  assign bus.rd_addr_b = rd_addr_b_c;
  assign bus.rd_swap   = rd_swap_c;
  assign bus.tf_addr   = tf_addr_c;
  assign bus.bypass_n  = bypass_n_c;
  assign bus.wr_en     = wr_vld;
  assign bus.wr_addr_a = wr_addr_a_c;
  assign bus.wr_addr_b = wr_addr_b_c;
  assign bus.wr_swap   = wr_swap_c;
endmodule

// File: tb/tb_fft_mem_sched.sv
// Directed bench for fft_mem_sched: default size (N=256, LAT=2) and small size (N=16, LAT=3).
`timescale 1ns/1ps
module tb_fft_mem_sched;
  logic Clk = 1'b0;
  logic Reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 Clk = ~Clk;

  fft_mem_sched_if #(.AW(6), .SW(4)) bus8 ();
  fft_mem_sched_if #(.AW(2), .SW(4)) bus4 ();

  fft_mem_sched #(.LOG2N(8), .LAT(2), .SW(4)) dut8 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus8.master)
  );
  fft_mem_sched #(.LOG2N(4), .LAT(3), .SW(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus4.master)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_rst8(input string tag);
    chk({tag, "_busy"},   32'(bus8.busy), 0);
    chk({tag, "_done"},   32'(bus8.done), 0);
    chk({tag, "_stage"},  32'(bus8.stage), 0);
    chk({tag, "_wr_en"},  32'(bus8.wr_en), 0);
    chk({tag, "_bypass"}, 32'(bus8.bypass_n), 1);
    chk({tag, "_swaps"},  32'(bus8.rd_swap | bus8.wr_swap), 0);
    chk({tag, "_addrs"},  32'(bus8.rd_addr_a | bus8.rd_addr_b | bus8.tf_addr |
                              bus8.wr_addr_a | bus8.wr_addr_b), 0);
  endtask

  // Full default-size run; read of rd_cnt r in stage k is at cycle 1+66k+r, its write 2 cycles later.
  task automatic run_big(input string tag, input bit poke);
    int busy_n, done_n, done_c, first_w, first_a;
    int wcnt[7];
    busy_n = 0; done_n = 0; done_c = -1; first_w = -1; first_a = -1;
    foreach (wcnt[i]) wcnt[i] = 0;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    for (int c = 1; c <= 470; c++) begin
      bus8.start = poke && (c == 200);
      case (c)
        1:   chk({tag, "_rd_a_c1"}, 32'(bus8.rd_addr_a), 0);
        5:   chk({tag, "_bypass_s0"}, 32'(bus8.bypass_n), 1);
        34:  chk({tag, "_tf_s0_r33"}, 32'(bus8.tf_addr), 33);
        36: begin
          chk({tag, "_wa_s0_r33"}, 32'(bus8.wr_addr_a), 33);
          chk({tag, "_wswap_s0_r33"}, 32'(bus8.wr_swap), 1);
        end
        66: begin
          chk({tag, "_drain_rd_a"}, 32'(bus8.rd_addr_a), 0);
          chk({tag, "_drain_wa"}, 32'(bus8.wr_addr_a), 63);
        end
        67: chk({tag, "_gap_wr_en67"}, 32'(bus8.wr_en), 0);
        68: chk({tag, "_gap_wr_en68"}, 32'(bus8.wr_en), 0);
        72: begin
          chk({tag, "_s1_stage"}, 32'(bus8.stage), 1);
          chk({tag, "_s1_r5_rdb"}, 32'(bus8.rd_addr_b), 37);
          chk({tag, "_s1_r5_swap"}, 32'(bus8.rd_swap), 0);
        end
        85: begin
          chk({tag, "_s1_w16_wb"}, 32'(bus8.wr_addr_b), 48);
          chk({tag, "_s1_w16_swap"}, 32'(bus8.wr_swap), 1);
        end
        107: begin
          chk({tag, "_s1_r40_rdb"}, 32'(bus8.rd_addr_b), 8);
          chk({tag, "_s1_r40_swap"}, 32'(bus8.rd_swap), 1);
        end
        154: chk({tag, "_s2_r21_tf"}, 32'(bus8.tf_addr), 20);
        402: begin
          chk({tag, "_s6_r5_rdb"}, 32'(bus8.rd_addr_b), 58);
          chk({tag, "_s6_bypass"}, 32'(bus8.bypass_n), 0);
        end
        462: begin
          chk({tag, "_s6_last_wa"}, 32'(bus8.wr_addr_a), 63);
          chk({tag, "_s6_last_wb"}, 32'(bus8.wr_addr_b), 0);
          chk({tag, "_s6_last_wswap"}, 32'(bus8.wr_swap), 0);
        end
        default: ;
      endcase
      if (bus8.busy) busy_n++;
      if (bus8.done) begin
        done_n++;
        done_c = c;
      end
      if (bus8.wr_en && first_w < 0) begin
        first_w = c;
        first_a = int'(bus8.wr_addr_a);
      end
      if (bus8.wr_en && bus8.stage < 7) wcnt[bus8.stage]++;
      step();
    end
    bus8.start = 1'b0;
    chk({tag, "_first_wr_cyc"}, 32'(first_w), 3);
    chk({tag, "_first_wr_addr"}, 32'(first_a), 0);
    chk({tag, "_done_count"}, 32'(done_n), 1);
    chk({tag, "_done_cyc"}, 32'(done_c), 463);
    chk({tag, "_busy_cycles"}, 32'(busy_n), 462);
    foreach (wcnt[i]) chk($sformatf("%s_writes_s%0d", tag, i), 32'(wcnt[i]), 64);
    chk({tag, "_busy_after"}, 32'(bus8.busy), 0);
  endtask

  initial begin
    int any_act, done_n, busy_n, first_w;
    int wcnt4[3];
    Reset_n    = 1'b0;
    bus8.start = 1'b0;
    bus4.start = 1'b0;
    step();
    step();
    Reset_n = 1'b1;
    chk_rst8("rst");
    chk("rst4_busy", 32'(bus4.busy), 0);

    any_act = 0;
    for (int c = 0; c < 20; c++) begin
      any_act |= int'(bus8.busy | bus8.done | bus8.wr_en | (|bus8.rd_addr_a) |
                      (|bus8.rd_addr_b) | (|bus8.wr_addr_a) | (|bus8.tf_addr) | (|bus8.stage));
      step();
    end
    chk("idle_activity", 32'(any_act), 0);

    run_big("run", 1'b1);

    // Abort in stage 3 (rd_cnt 10 at cycle 1+3*66+10).
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    for (int c = 1; c < 209; c++) step();
    chk("abort_pre_stage", 32'(bus8.stage), 3);
    chk("abort_pre_rd_a", 32'(bus8.rd_addr_a), 10);
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    chk_rst8("abort");
    any_act = 0;
    for (int c = 0; c < 30; c++) begin
      any_act |= int'(bus8.done | bus8.wr_en | bus8.busy);
      step();
    end
    chk("abort_quiet", 32'(any_act), 0);
    run_big("rerun", 1'b0);

    // Small size: M=4, S=3, period 7, busy 21 cycles, done at cycle 22.
    done_n = 0; busy_n = 0; first_w = -1;
    foreach (wcnt4[i]) wcnt4[i] = 0;
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 10) begin
        chk("n16_s1_r2_rdb", 32'(bus4.rd_addr_b), 0);
        chk("n16_s1_r2_swap", 32'(bus4.rd_swap), 1);
      end
      if (c == 16) begin
        chk("n16_s2_r1_rdb", 32'(bus4.rd_addr_b), 2);
        chk("n16_s2_bypass", 32'(bus4.bypass_n), 0);
      end
      if (c == 22) chk("n16_done_cyc", 32'(bus4.done), 1);
      if (bus4.busy) busy_n++;
      if (bus4.done) done_n++;
      if (bus4.wr_en && first_w < 0) first_w = c;
      if (bus4.wr_en && bus4.stage < 3) wcnt4[bus4.stage]++;
      step();
    end
    chk("n16_first_wr_cyc", 32'(first_w), 4);
    chk("n16_busy_cycles", 32'(busy_n), 21);
    chk("n16_done_count", 32'(done_n), 1);
    foreach (wcnt4[i]) chk($sformatf("n16_writes_s%0d", i), 32'(wcnt4[i]), 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
